// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin write arbiter in front of a single FIFO write port.
//               One requester owns the port at a time and may write up to
//               MAX_BURST beats per grant. Bursts stall on FIFO full, end early
//               when the owner drops its request, and are separated by
//               exactly one IDLE (arbitration) cycle.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      width of one FIFO write word
//   NREQ       number of write requesters (2..8)
//   MAX_BURST  maximum accepted beats per grant (1..16)
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (priority over clr)
//   clr        synchronous active-high flush, same effect as rst
//   req        per-requester write request, bit i = requester i
//   data_in    requester i word at [i*WIDTH +: WIDTH]
//   full       FIFO full; 1 = no write accepted this cycle
//   gnt        registered one-hot grant, zero when no owner
//   ack        one-hot beat accept; ack[i] = word i written this cycle
//   wr_en      write strobe to FIFO write pointer and memory
//   wr_data    word written when wr_en = 1
//   busy       1 while a burst is in progress
// ============================================================================
module fifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  input  logic                  full,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
  localparam logic [IDXW:0]   NREQ_EXT  = (IDXW + 1)'(NREQ);

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  logic [0:0]      state,     state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDXW-1:0] gidx,      gidx_nxt;    // binary form of the current grant
  logic [IDXW-1:0] rr_ptr,    rr_nxt;      // first candidate of next arbitration
  logic [CNTW-1:0] beat_cnt,  cnt_nxt;

  logic            flush;
  logic            req_g;
  logic            sel_valid;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW:0]   cand;

  logic [WIDTH-1:0] words [NREQ];

  assign flush = rst | clr;

  // --------------------------------------------------------------------------
  // Unpack the flat data bus into one word per requester
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign words[i] = data_in[i*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // Round-robin selector: scan offsets from rr_ptr downwards so that the
  // smallest offset (closest at or after rr_ptr, with wrap) is written last
  // and therefore wins.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDXW + 1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (req[cand[IDXW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IDXW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 1: state register (flush dominates every other event)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (flush) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gidx     <= gidx_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      ST_IDLE: begin
        // A full FIFO blocks arbitration as well as writes, so a grant is
        // never issued that could not make progress.
        if (sel_valid && !full) begin
          state_nxt         = ST_BURST;
          gnt_nxt           = '0;
          gnt_nxt[sel_idx]  = 1'b1;
          gidx_nxt          = sel_idx;
          cnt_nxt           = '0;
        end
      end
      ST_BURST: begin
        if (!req_g || (wr_en && (beat_cnt == LAST_BEAT))) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          rr_nxt    = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
        end else if (wr_en) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs. The write strobe is combinational so a beat is
  // accepted in the same cycle the owner presents it; flush suppresses it so
  // nothing is written while the block is being cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    req_g   = req[gidx];
    wr_en   = 1'b0;
    ack     = '0;
    wr_data = '0;
    busy    = 1'b0;
    if (state == ST_BURST) begin
      wr_data = words[gidx];
      if (!flush) begin
        busy  = 1'b1;
        wr_en = req_g & ~full;
      end
    end
    if (wr_en) begin
      ack[gidx] = 1'b1;
    end
  end

endmodule
`default_nettype wire
